end_screen_rgb: RTL and testbench
=================================

Name: end_screen_rgb

Overview:
- Parametrised end-of-game screen pixel generator. It is the successor to the fixed single-colour "done/lose" fill.
- Driven by the VGA timing counters (hCount, vCount, bright).
- Renders a win or lose banner over a background, with a frame-stepped fade-in followed by an optional blinking hold.
- Output rgb is registered and feeds the display mux in place of the game-scene colour once the game ends.

Parameters:
- WIN_COLOR, 12'h0F0, banner colour when the latched mode is win.
- LOSE_COLOR, 12'hF00, banner colour when the latched mode is lose.
- BG_COLOR, 12'h000, colour outside the banner.
- BANNER_X0, 10'd144, banner left column, inclusive.
- BANNER_X1, 10'd783, banner right column, inclusive.
- BANNER_Y0, 10'd200, banner top row, inclusive.
- BANNER_Y1, 10'd350, banner bottom row, inclusive.
- FADE_FRAMES, 4, frames per fade level step. Must be ≥1.
- BLINK_FRAMES, 30, frames per blink half-period in HOLD. Must be ≥1.
- BLINK_EN, 1, 1 = banner blinks in HOLD; 0 = banner is solid in HOLD.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse; latches win and (re)starts the fade
- win  input  1  mode sampled on start: 1 = win, 0 = lose
- bright  input  1  1 = visible pixel region
- hCount  input  10  current pixel column
- vCount  input  10  current pixel row
- rgb  output  12  registered pixel colour {R[3:0],G[3:0],B[3:0]}
- active  output  1  high in FADE or HOLD
- fade_done  output  1  high in HOLD

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, level=0, frame_cnt=0, blink_phase=0, mode=0.
  - rgb=12'h000, active=0, fade_done=0.
  - Reset mid-fade or mid-hold returns to these values immediately.
- Frame tick:
  - tick=1 for exactly one clk on the first cycle in which (hCount,vCount)==(0,0).
  - Detection compares against a registered previous-(0,0) flag, so it works when the pixel clock is slower than clk.
  - The previous-(0,0) flag resets to 1, so no tick is generated on the first cycle out of reset.
- States:
  - IDLE: rgb=0. On start: mode<=win, level<=0, frame_cnt<=0, go to FADE.
  - FADE: on each tick, frame_cnt++. When frame_cnt reaches FADE_FRAMES-1 on a tick: frame_cnt<=0 and level++. On the tick where level==15 and frame_cnt==FADE_FRAMES-1: go to HOLD with blink_phase=0 and frame_cnt=0.
  - HOLD: level stays at 15. If BLINK_EN, on each tick frame_cnt++; at BLINK_FRAMES-1, frame_cnt<=0 and blink_phase toggles. Stays in HOLD until reset or start.
  - start in any state (FADE or HOLD included) restarts: re-latches mode, level<=0, frame_cnt<=0, state<=FADE. start has priority over a coincident tick.
- Pixel colour:
  - Computed combinationally from current inputs and state, then registered. Latency is 1 clk from hCount/vCount/bright to rgb.
  - bright=0 → 12'h000, regardless of state.
  - IDLE → 12'h000.
  - in_banner = BANNER_X0≤hCount≤BANNER_X1 and BANNER_Y0≤vCount≤BANNER_Y1. The compare is unsigned and the bounds are inclusive.
  - Base colour = (mode ? WIN_COLOR : LOSE_COLOR) when in_banner and not (HOLD and BLINK_EN and blink_phase==1). Otherwise base colour = BG_COLOR.
  - Scaling: each 4-bit channel out = min(base_channel, level). At level 0 the output is all black; at level 15 it is the unmodified colour.
- Counters: frame_cnt is max($clog2(FADE_FRAMES),$clog2(BLINK_FRAMES),1) bits wide. level is 4 bits and never wraps.
- Outputs: active and fade_done are registered decodes of the next state, so they change on the same edge as the state.

Decomposition:
- Shared package vga_pkg holds:
  - the colour type (12-bit RGB) and the BLACK/WHITE/RED/GREEN constants;
  - the state enum {IDLE, FADE, HOLD};
  - the screen size constants (640x480 visible, 10-bit counters).
- One sub-module: vga_frame_tick. It takes clk, reset, hCount and vCount and produces the single-cycle tick. It is reusable by other animated sprite blocks.
- Scaling and region compare stay inline.

Test Plan:
- Reset with start=1, win=1 held low for 3 clk → rgb=12'h000, active=0, fade_done=0. No tick on the first cycle out of reset.
- win=1, start pulse, FADE_FRAMES=1 → rgb=12'h000 at banner pixel (300,250) until the first tick. Then banner pixel reads 12'h010, 12'h020, … on successive frames. HOLD and fade_done=1 are entered on the 16th tick. Banner = 12'h0F0, background (10,10) = 12'h000.
- win=0, LOSE_COLOR=12'hF00, BG_COLOR=12'h333, level 5 → banner 12'h500, background 12'h333. bright=0 at the same coordinates → 12'h000 one clk later.
- HOLD with BLINK_EN=1, BLINK_FRAMES=2 → banner pixel alternates between 12'h0F0 and BG_COLOR every 2 ticks.
- start pulse while in HOLD with win=0 → next clk level=0, state FADE, mode=lose, fade_done=0, active=1.
- Reset asserted mid-FADE at level 7 → rgb=0 and active=0 asynchronously (before the next clk edge). After release, state is IDLE and the output stays black until start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: colour type, named colours, end-screen states and
// screen geometry for the 640x480 timing generator.
package vga_pkg;

    localparam int CNT_W     = 10;
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    typedef logic [11:0] color_t;

    localparam color_t BLACK = 12'h000;
    localparam color_t WHITE = 12'hFFF;
    localparam color_t RED   = 12'hF00;
    localparam color_t GREEN = 12'h0F0;

    typedef enum logic [1:0] {
        IDLE,
        FADE,
        HOLD
    } state_t;

endpackage

// File: rtl/vga_frame_tick.sv
// One-clk pulse on the first clk cycle the scan position sits at (0,0);
// edge detection keeps it single even when the pixel clock is slower than clk.
module vga_frame_tick
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] hCount,
    input  logic [CNT_W-1:0] vCount,
    output logic             tick
);

    logic at_origin;
    logic prev_origin_reg;

    assign at_origin = (hCount == '0) && (vCount == '0);

    // Reset to 1 so the first cycle out of reset never produces a tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_origin_reg <= 1'b1;
        end else begin
            prev_origin_reg <= at_origin;
        end
    end

    assign tick = at_origin & ~prev_origin_reg;

endmodule

// File: rtl/end_screen_rgb.sv
// End-of-game screen: win/lose banner over a background, faded in one level
// per FADE_FRAMES frames, then held (optionally blinking). Registered rgb output.
module end_screen_rgb
    import vga_pkg::*;
#(
    parameter color_t         WIN_COLOR    = 12'h0F0,
    parameter color_t         LOSE_COLOR   = 12'hF00,
    parameter color_t         BG_COLOR     = 12'h000,
    parameter logic [CNT_W-1:0] BANNER_X0  = 10'd144,
    parameter logic [CNT_W-1:0] BANNER_X1  = 10'd783,
    parameter logic [CNT_W-1:0] BANNER_Y0  = 10'd200,
    parameter logic [CNT_W-1:0] BANNER_Y1  = 10'd350,
    parameter int             FADE_FRAMES  = 4,
    parameter int             BLINK_FRAMES = 30,
    parameter bit             BLINK_EN     = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             win,
    input  logic             bright,
    input  logic [CNT_W-1:0] hCount,
    input  logic [CNT_W-1:0] vCount,
    output logic [11:0]      rgb,
    output logic             active,
    output logic             fade_done
);

    localparam int FW  = $clog2(FADE_FRAMES);
    localparam int BW  = $clog2(BLINK_FRAMES);
    localparam int FBW = (FW > BW) ? FW : BW;
    localparam int CW  = (FBW > 1) ? FBW : 1;

    localparam logic [CW-1:0] FADE_LAST  = CW'(FADE_FRAMES - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

    state_t          state_reg, state_next;
    logic [3:0]      level_reg, level_next;
    logic [CW-1:0]   frame_cnt_reg, frame_cnt_next;
    logic            blink_phase_reg, blink_phase_next;
    logic            mode_reg, mode_next;
    color_t          rgb_reg, pixel_next;
    logic            active_reg, fade_done_reg;

    logic            tick;
    logic            in_banner;
    logic            blanked;
    color_t          base_color;
    color_t          scaled_color;

    vga_frame_tick u_frame_tick (
        .clk    (clk),
        .reset  (reset),
        .hCount (hCount),
        .vCount (vCount),
        .tick   (tick)
    );

    always_comb begin
        state_next       = state_reg;
        level_next       = level_reg;
        frame_cnt_next   = frame_cnt_reg;
        blink_phase_next = blink_phase_reg;
        mode_next        = mode_reg;

        if (start) begin
            mode_next      = win;
            level_next     = 4'd0;
            frame_cnt_next = '0;
            state_next     = FADE;
        end else if (tick) begin
            case (state_reg)
                FADE: begin
                    if (frame_cnt_reg == FADE_LAST) begin
                        frame_cnt_next = '0;
                        if (level_reg == 4'hF) begin
                            state_next       = HOLD;
                            blink_phase_next = 1'b0;
                        end else begin
                            level_next = level_reg + 4'd1;
                        end
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (BLINK_EN) begin
                        if (frame_cnt_reg == BLINK_LAST) begin
                            frame_cnt_next   = '0;
                            blink_phase_next = ~blink_phase_reg;
                        end else begin
                            frame_cnt_next = frame_cnt_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_banner = (hCount >= BANNER_X0) && (hCount <= BANNER_X1) &&
                       (vCount >= BANNER_Y0) && (vCount <= BANNER_Y1);
    assign blanked    = (state_reg == HOLD) && BLINK_EN && blink_phase_reg;
    assign base_color = (in_banner && !blanked) ? (mode_reg ? WIN_COLOR : LOSE_COLOR)
                                                : BG_COLOR;

    // Fade by clamping each channel to the current level.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign scaled_color[gi*4 +: 4] = (base_color[gi*4 +: 4] < level_reg) ?
                                         base_color[gi*4 +: 4] : level_reg;
    end

    assign pixel_next = (!bright || state_reg == IDLE) ? BLACK : scaled_color;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            level_reg       <= 4'd0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            mode_reg        <= 1'b0;
            rgb_reg         <= BLACK;
            active_reg      <= 1'b0;
            fade_done_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            level_reg       <= level_next;
            frame_cnt_reg   <= frame_cnt_next;
            blink_phase_reg <= blink_phase_next;
            mode_reg        <= mode_next;
            rgb_reg         <= pixel_next;
            active_reg      <= (state_next != IDLE);
            fade_done_reg   <= (state_next == HOLD);
        end
    end

    assign rgb       = rgb_reg;
    assign active    = active_reg;
    assign fade_done = fade_done_reg;

endmodule

// File: tb/tb_end_screen_rgb.sv
// Directed scoreboard bench for end_screen_rgb: the driver queues expected
// rgb/active/fade_done per pixel; a negedge monitor pops and compares.
module tb_end_screen_rgb;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        win;
    logic        bright;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic [11:0] rgb;
    logic        active;
    logic        fade_done;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        string       name;
        logic [11:0] rgb;
        logic        act;
        logic        done;
    } exp_t;

    exp_t exp_q[$];

    end_screen_rgb #(
        .WIN_COLOR    (12'h0F0),
        .LOSE_COLOR   (12'hF00),
        .BG_COLOR     (12'h333),
        .BANNER_X0    (10'd144),
        .BANNER_X1    (10'd783),
        .BANNER_Y0    (10'd200),
        .BANNER_Y1    (10'd350),
        .FADE_FRAMES  (1),
        .BLINK_FRAMES (2),
        .BLINK_EN     (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .win       (win),
        .bright    (bright),
        .hCount    (hCount),
        .vCount    (vCount),
        .rgb       (rgb),
        .active    (active),
        .fade_done (fade_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [11:0] er, input logic ea, input logic ed);
        tests_run++;
        if (rgb !== er || active !== ea || fade_done !== ed) begin
            tests_failed++;
            $display("[TB] FAIL %s: got rgb=%h active=%b fade_done=%b, expected rgb=%h active=%b fade_done=%b",
                     nm, rgb, active, fade_done, er, ea, ed);
        end else begin
            $display("[TB] ok   %s: rgb=%h active=%b fade_done=%b", nm, rgb, active, fade_done);
        end
    endtask

    // Monitor: registered outputs are compared one cycle after the pixel was driven.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, e.rgb, e.act, e.done);
        end
    end

    task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic b,
                       input logic s, input logic w, input string nm,
                       input logic [11:0] er, input logic ea, input logic ed);
        exp_t e;
        @(posedge clk);
        #1;
        hCount = h;
        vCount = v;
        bright = b;
        start  = s;
        win    = w;
        e.due  = cyc + 1;
        e.name = nm;
        e.rgb  = er;
        e.act  = ea;
        e.done = ed;
        exp_q.push_back(e);
    endtask

    task automatic frame_tick();
        @(posedge clk);
        #1;
        hCount = 10'd0;
        vCount = 10'd0;
        start  = 1'b0;
        bright = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] e;

        reset  = 1'b0;
        start  = 1'b1;
        win    = 1'b1;
        bright = 1'b1;
        hCount = 10'd0;
        vCount = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 12'h000, 1'b0, 1'b0);
        start = 1'b0;
        reset = 1'b1;

        pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b1, "idle_banner", 12'h000, 1'b0, 1'b0);
        pix(10'd300, 10'd250, 1'b1, 1'b1, 1'b1, "start_win", 12'h000, 1'b1, 1'b0);
        pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b0, "fade_lvl0", 12'h000, 1'b1, 1'b0);

        for (int k = 1; k <= 15; k++) begin
            frame_tick();
            e = 12'(k) << 4;
            pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b0, $sformatf("win_lvl%0d", k), e, 1'b1, 1'b0);
            if (k == 1)
                pix(10'd10, 10'd10, 1'b1, 1'b0, 1'b0, "bg_lvl1", 12'h111, 1'b1, 1'b0);
        end

        frame_tick();
        pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b0, "hold_banner", 12'h0F0, 1'b1, 1'b1);
        pix(10'd10,  10'd10,  1'b1, 1'b0, 1'b0, "hold_bg",     12'h333, 1'b1, 1'b1);
        pix(10'd144, 10'd200, 1'b1, 1'b0, 1'b0, "edge_x0y0",   12'h0F0, 1'b1, 1'b1);
        pix(10'd143, 10'd200, 1'b1, 1'b0, 1'b0, "left_out",    12'h333, 1'b1, 1'b1);
        pix(10'd783, 10'd350, 1'b1, 1'b0, 1'b0, "edge_x1y1",   12'h0F0, 1'b1, 1'b1);
        pix(10'd784, 10'd350, 1'b1, 1'b0, 1'b0, "right_out",   12'h333, 1'b1, 1'b1);
        pix(10'd144, 10'd199, 1'b1, 1'b0, 1'b0, "top_out",     12'h333, 1'b1, 1'b1);
        pix(10'd300, 10'd351, 1'b1, 1'b0, 1'b0, "bottom_out",  12'h333, 1'b1, 1'b1);

        frame_tick();
        pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b0, "blink_t1", 12'h0F0, 1'b1, 1'b1);
        frame_tick();
        pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b0, "blink_t2", 12'h333, 1'b1, 1'b1);
        frame_tick();
        pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b0, "blink_t3", 12'h333, 1'b1, 1'b1);
        frame_tick();
        pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b0, "blink_t4", 12'h0F0, 1'b1, 1'b1);

        pix(10'd300, 10'd250, 1'b1, 1'b1, 1'b0, "restart_lose", 12'h0F0, 1'b1, 1'b0);
        pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b1, "lose_lvl0", 12'h000, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            frame_tick();
            e = 12'(k) << 8;
            pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b0, $sformatf("lose_lvl%0d", k), e, 1'b1, 1'b0);
        end
        pix(10'd10,  10'd10,  1'b1, 1'b0, 1'b0, "lose_bg_lvl5", 12'h333, 1'b1, 1'b0);
        pix(10'd300, 10'd250, 1'b0, 1'b0, 1'b0, "blank_lvl5",   12'h000, 1'b1, 1'b0);
        frame_tick();
        pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b0, "lose_lvl6", 12'h600, 1'b1, 1'b0);
        frame_tick();
        pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b0, "lose_lvl7", 12'h700, 1'b1, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset", 12'h000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b0, "post_reset", 12'h000, 1'b0, 1'b0);
        frame_tick();
        pix(10'd300, 10'd250, 1'b1, 1'b0, 1'b0, "post_reset_tick", 12'h000, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
